seg7_capture: RTL and testbench



---
 rtl/seg7_capture_if.sv | 23 ++
 rtl/seg7_capture.sv | 124 ++++++++++++
 tb/tb_seg7_capture.sv | 182 ++++++++++++++++++
 3 files changed

// File: rtl/seg7_capture_if.sv
// Segment-pattern loopback bus: the pattern fed in plus the decoded digit,
// pulses, BCD history and counters reported back.
interface seg7_capture_if #(
  parameter int unsigned DIGITS = 4
);
  logic [6:0]          SEG_IN;
  logic [3:0]          DIGIT_OUT;
  logic                DIGIT_VALID;
  logic                SEG_ERR;
  logic [4*DIGITS-1:0] BCD_OUT;
  logic [3:0]          DIGIT_COUNT;
  logic [7:0]          ERR_COUNT;

  modport master (
    output SEG_IN,
    input  DIGIT_OUT, DIGIT_VALID, SEG_ERR, BCD_OUT, DIGIT_COUNT, ERR_COUNT
  );

  modport slave (
    input  SEG_IN,
    output DIGIT_OUT, DIGIT_VALID, SEG_ERR, BCD_OUT, DIGIT_COUNT, ERR_COUNT
  );
endinterface

// File: rtl/seg7_capture.sv
// Debounces an active-low 7-segment pattern, decodes it back to a decimal
// digit, shifts accepted digits into a BCD history and counts illegal patterns.
module seg7_capture #(
  parameter int unsigned STABLE_CYCLES = 4,
  parameter int unsigned DIGITS        = 4
) (
  input  logic           Clock,
  input  logic           Reset,
  input  logic           Clear,
  seg7_capture_if.slave  bus
);
  localparam int unsigned W       = 4 * DIGITS;
  localparam logic [3:0]  STB     = 4'(STABLE_CYCLES);
  localparam logic [3:0]  DIG_MAX = 4'(DIGITS);
  localparam logic [6:0]  BLANK   = 7'h7F;

  localparam logic [0:0] ST_WAIT = 1'b0;
  localparam logic [0:0] ST_HOLD = 1'b1;

  logic [6:0]   seg_q, seg_d;
  logic [3:0]   stable_cnt_q, stable_cnt_d;
  logic [0:0]   state_q, state_d;
  logic [3:0]   digit_q, digit_d;
  logic         valid_q, valid_d;
  logic         err_q, err_d;
  logic [W-1:0] bcd_q, bcd_d;
  logic [3:0]   dcnt_q, dcnt_d;
  logic [7:0]   ecnt_q, ecnt_d;

  logic         same;
  logic         accept;
  logic         is_digit;
  logic         is_blank;
  logic [3:0]   dec;
  logic [W+3:0] bcd_ext;

  always_comb begin
    dec      = 4'd0;
    is_digit = 1'b1;
    case (seg_q)
      7'h40:   dec = 4'd0;
      7'h79:   dec = 4'd1;
      7'h24:   dec = 4'd2;
      7'h30:   dec = 4'd3;
      7'h19:   dec = 4'd4;
      7'h12:   dec = 4'd5;
      7'h02:   dec = 4'd6;
      7'h78:   dec = 4'd7;
      7'h00:   dec = 4'd8;
      7'h10:   dec = 4'd9;
      default: is_digit = 1'b0;
    endcase
    is_blank = (seg_q == BLANK);
  end

  always_comb begin
    same    = (bus.SEG_IN == seg_q);
    // Acceptance also needs the current edge's sample to match, so a pattern
    // must span STABLE_CYCLES+1 edges before it is taken.
    accept  = (state_q == ST_WAIT) && same && (stable_cnt_q == STB);
    bcd_ext = {bcd_q, dec};

    seg_d        = bus.SEG_IN;
    stable_cnt_d = stable_cnt_q;
    state_d      = state_q;
    if (!same) begin
      stable_cnt_d = 4'd1;
      state_d      = ST_WAIT;
    end else begin
      if (stable_cnt_q < STB) stable_cnt_d = stable_cnt_q + 4'd1;
      if (accept)             state_d      = ST_HOLD;
    end

    valid_d = accept && is_digit && !Clear;
    err_d   = accept && !is_digit && !is_blank && !Clear;
    digit_d = valid_d ? dec : digit_q;

    bcd_d  = bcd_q;
    dcnt_d = dcnt_q;
    ecnt_d = ecnt_q;
    if (Clear) begin
      bcd_d  = '0;
      dcnt_d = '0;
      ecnt_d = '0;
    end else begin
      if (valid_d) begin
        bcd_d = bcd_ext[W-1:0];
        if (dcnt_q < DIG_MAX) dcnt_d = dcnt_q + 4'd1;
      end
      if (err_d && ecnt_q != 8'hFF) ecnt_d = ecnt_q + 8'd1;
    end
  end

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      seg_q        <= BLANK;
      stable_cnt_q <= '0;
      state_q      <= ST_WAIT;
      digit_q      <= '0;
      valid_q      <= 1'b0;
      err_q        <= 1'b0;
      bcd_q        <= '0;
      dcnt_q       <= '0;
      ecnt_q       <= '0;
    end else begin
      seg_q        <= seg_d;
      stable_cnt_q <= stable_cnt_d;
      state_q      <= state_d;
      digit_q      <= digit_d;
      valid_q      <= valid_d;
      err_q        <= err_d;
      bcd_q        <= bcd_d;
      dcnt_q       <= dcnt_d;
      ecnt_q       <= ecnt_d;
    end
  end

  assign bus.DIGIT_OUT   = digit_q;
  assign bus.DIGIT_VALID = valid_q;
  assign bus.SEG_ERR     = err_q;
  assign bus.BCD_OUT     = bcd_q;
  assign bus.DIGIT_COUNT = dcnt_q;
  assign bus.ERR_COUNT   = ecnt_q;
endmodule

// File: tb/tb_seg7_capture.sv
// Directed bench for seg7_capture: debounce latency, BCD shifting, HOLD
// re-arm, error saturation, Clear priority and asynchronous reset.
module tb_seg7_capture;
  logic Clock = 1'b0;
  logic Reset;
  logic Clear;

  seg7_capture_if #(.DIGITS(4)) sif ();

  seg7_capture #(.STABLE_CYCLES(4), .DIGITS(4)) dut (
    .Clock (Clock),
    .Reset (Reset),
    .Clear (Clear),
    .bus   (sif)
  );

  always #5 Clock = ~Clock;

  int checks = 0;
  int errors = 0;
  int vcnt   = 0;
  int ecnt   = 0;
  int both   = 0;
  int v0;
  int e0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge Clock);
    #1;
    if (sif.DIGIT_VALID === 1'b1) vcnt++;
    if (sif.SEG_ERR === 1'b1) ecnt++;
    if (sif.DIGIT_VALID === 1'b1 && sif.SEG_ERR === 1'b1) both++;
  endtask

  task automatic hold(input logic [6:0] p, input int unsigned n);
    sif.SEG_IN = p;
    for (int unsigned i = 0; i < n; i++) tick();
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_dout"},  32'(sif.DIGIT_OUT),   32'h0);
    check({tag, "_valid"}, 32'(sif.DIGIT_VALID), 32'h0);
    check({tag, "_err"},   32'(sif.SEG_ERR),     32'h0);
    check({tag, "_bcd"},   32'(sif.BCD_OUT),     32'h0);
    check({tag, "_dcnt"},  32'(sif.DIGIT_COUNT), 32'h0);
    check({tag, "_ecnt"},  32'(sif.ERR_COUNT),   32'h0);
  endtask

  logic [6:0] pats [5] = '{7'h79, 7'h24, 7'h30, 7'h19, 7'h12};

  initial begin
    Reset      = 1'b1;
    Clear      = 1'b0;
    sif.SEG_IN = 7'h7F;
    #1;
    check_all_zero("reset");
    tick();
    tick();
    Reset = 1'b0;

    // Single digit 3: five edges, pulse after the fifth.
    v0 = vcnt;
    hold(7'h30, 4);
    check("lat_early", 32'(vcnt - v0), 32'd0);
    hold(7'h30, 1);
    check("d3_valid", 32'(sif.DIGIT_VALID), 32'h1);
    check("d3_dout",  32'(sif.DIGIT_OUT),   32'h3);
    check("d3_bcd",   32'(sif.BCD_OUT),     32'h0003);
    check("d3_dcnt",  32'(sif.DIGIT_COUNT), 32'h1);
    hold(7'h7F, 1);
    check("d3_pulse_drop", 32'(sif.DIGIT_VALID), 32'h0);
    hold(7'h7F, 4);

    // Digits 1..5 separated by blanks.
    v0 = vcnt;
    for (int i = 0; i < 5; i++) begin
      hold(pats[i], 5);
      hold(7'h7F, 5);
    end
    check("seq_pulses", 32'(vcnt - v0), 32'd5);
    check("seq_bcd",    32'(sif.BCD_OUT),     32'h2345);
    check("seq_dcnt",   32'(sif.DIGIT_COUNT), 32'h4);

    // Short glitch of 2 followed by a stable 1.
    v0 = vcnt;
    hold(7'h24, 3);
    hold(7'h79, 5);
    check("glitch_pulses", 32'(vcnt - v0), 32'd1);
    check("glitch_dout",   32'(sif.DIGIT_OUT), 32'h1);
    check("glitch_bcd",    32'(sif.BCD_OUT),   32'h3451);

    // Clear outside an accept, then long hold and single-edge blank re-arm.
    sif.SEG_IN = 7'h7F;
    Clear = 1'b1;
    tick();
    Clear = 1'b0;
    check("clr_bcd",  32'(sif.BCD_OUT),     32'h0);
    check("clr_dcnt", 32'(sif.DIGIT_COUNT), 32'h0);
    check("clr_dout", 32'(sif.DIGIT_OUT),   32'h1);
    hold(7'h7F, 4);
    v0 = vcnt;
    hold(7'h12, 20);
    check("long_hold_pulses", 32'(vcnt - v0), 32'd1);
    hold(7'h7F, 1);
    hold(7'h12, 5);
    check("rearm_pulses", 32'(vcnt - v0), 32'd2);
    check("rearm_dcnt",   32'(sif.DIGIT_COUNT), 32'h2);
    check("rearm_bcd",    32'(sif.BCD_OUT),     32'h0055);

    // Illegal pattern and error-count saturation.
    hold(7'h7F, 5);
    e0 = ecnt;
    hold(7'h55, 5);
    check("ill_err",   32'(sif.SEG_ERR),   32'h1);
    check("ill_valid", 32'(sif.DIGIT_VALID), 32'h0);
    check("ill_ecnt",  32'(sif.ERR_COUNT), 32'h1);
    check("ill_bcd",   32'(sif.BCD_OUT),   32'h0055);
    check("ill_dout",  32'(sif.DIGIT_OUT), 32'h5);
    for (int i = 0; i < 256; i++) begin
      hold(7'h7F, 1);
      hold(7'h55, 5);
    end
    check("sat_pulses", 32'(ecnt - e0),       32'd257);
    check("sat_ecnt",   32'(sif.ERR_COUNT),   32'hFF);
    check("sat_dcnt",   32'(sif.DIGIT_COUNT), 32'h2);

    // Clear on the accept edge of 8 suppresses it until the pattern changes.
    hold(7'h7F, 5);
    v0 = vcnt;
    hold(7'h00, 4);
    Clear = 1'b1;
    tick();
    Clear = 1'b0;
    check("clracc_valid", 32'(sif.DIGIT_VALID), 32'h0);
    check("clracc_bcd",   32'(sif.BCD_OUT),     32'h0);
    check("clracc_ecnt",  32'(sif.ERR_COUNT),   32'h0);
    check("clracc_dcnt",  32'(sif.DIGIT_COUNT), 32'h0);
    hold(7'h00, 10);
    check("clracc_nopulse", 32'(vcnt - v0), 32'd0);
    hold(7'h7F, 1);
    hold(7'h00, 5);
    check("clracc_rearm", 32'(vcnt - v0), 32'd1);
    check("clracc_dout",  32'(sif.DIGIT_OUT), 32'h8);
    check("clracc_bcd2",  32'(sif.BCD_OUT),   32'h0008);

    // Reset mid-pulse and mid-count.
    hold(7'h7F, 1);
    hold(7'h19, 5);
    check("pre_rst_valid", 32'(sif.DIGIT_VALID), 32'h1);
    Reset = 1'b1;
    #1;
    check_all_zero("rst_pulse");
    tick();
    Reset = 1'b0;
    sif.SEG_IN = 7'h24;
    hold(7'h24, 2);
    Reset = 1'b1;
    #1;
    check_all_zero("rst_count");
    tick();
    Reset = 1'b0;
    v0 = vcnt;
    hold(7'h19, 4);
    check("post_rst_early", 32'(vcnt - v0), 32'd0);
    hold(7'h19, 1);
    check("post_rst_valid", 32'(sif.DIGIT_VALID), 32'h1);
    check("post_rst_dout",  32'(sif.DIGIT_OUT),   32'h4);

    check("never_both", 32'(both), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
